// File: rtl/apb_memtest_master.sv
// apb_memtest_master: APB master running RAW and RAAWA memory tests over a row of slaves
module apb_memtest_master #(
    parameter int          P_NUM         = 3,
    parameter int          P_DWIDTH      = 32,
    parameter logic [31:0] P_ADDR_BASE   = 32'h0000_0000,
    parameter logic [31:0] P_ADDR_STRIDE = 32'h1000_0000,
    parameter int          P_WORDS       = 4,
    parameter logic [31:0] P_SEED        = 32'h1234_5678,
    parameter int          P_TIMEOUT     = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         start,
    output logic [P_NUM-1:0]             PSEL,
    output logic [31:0]                  PADDR,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [P_DWIDTH-1:0]          PWDATA,
    input  logic [P_NUM*P_DWIDTH-1:0]    PRDATA,
    input  logic [P_NUM-1:0]             PREADY,
    input  logic [P_NUM-1:0]             PSLVERR,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [15:0]                  err_cnt,
    output logic [31:0]                  first_err_addr
);
    localparam int SW = P_NUM > 1 ? $clog2(P_NUM) : 1;
    localparam int WW = P_WORDS > 1 ? $clog2(P_WORDS) : 1;
    localparam int TW = $clog2(P_TIMEOUT + 1);
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0] BYTES = 32'(P_DWIDTH / 8);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    state_t r_state, w_next;

    logic [SW-1:0]       r_slv, w_n_slv;
    logic [WW-1:0]       r_word, w_n_word;
    logic                r_phase, w_n_phase, r_rd, w_n_rd;
    logic [TW-1:0]       r_tmo;
    logic [31:0]         r_lfsr, r_saved, w_lfsr_nx, w_lfsr_step, w_n_addr;
    logic                w_rdy, w_slverr, w_tmo, w_complete, w_last, w_err, w_last_word, w_start;
    logic [P_DWIDTH-1:0] w_rdata;

    function automatic logic [31:0] f_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
    endfunction

    assign busy        = r_state == SETUP || r_state == ACCESS;
    assign done        = r_state == DONE;
    assign PENABLE     = r_state == ACCESS;
    assign w_start     = r_state == IDLE && start;
    assign w_last_word = r_word == WW'(P_WORDS - 1);
    assign w_tmo       = r_state == ACCESS && !w_rdy && r_tmo == TW'(P_TIMEOUT - 1);
    assign w_complete  = r_state == ACCESS && (w_rdy || w_tmo);
    assign w_err       = w_tmo || (w_complete && (w_slverr || (!PWRITE && w_rdata != r_lfsr[P_DWIDTH-1:0])));
    assign w_n_addr    = P_ADDR_BASE + 32'(w_n_slv) * P_ADDR_STRIDE + 32'(w_n_word) * BYTES;

    always_comb begin
        PSEL     = '0;
        w_rdy    = 1'b0;
        w_slverr = 1'b0;
        w_rdata  = '0;
        for (int k = 0; k < P_NUM; k++) begin
            PSEL[k] = busy && r_slv == SW'(k);
            if (r_slv == SW'(k)) begin
                w_rdy    = PREADY[k];
                w_slverr = PSLVERR[k];
                w_rdata  = PRDATA[k*P_DWIDTH +: P_DWIDTH];
            end
        end
    end

    // Walk order: RAW alternates write/read per word; RAAWA writes all words, then reads all words
    always_comb begin
        w_n_slv     = r_slv;
        w_n_phase   = r_phase;
        w_n_word    = r_word;
        w_n_rd      = r_rd;
        w_last      = 1'b0;
        w_lfsr_step = f_step(r_lfsr);
        w_lfsr_nx   = r_lfsr;
        if (!r_phase) begin
            w_n_rd = !r_rd;
            if (r_rd) begin
                w_lfsr_nx = w_lfsr_step;
                w_n_word  = w_last_word ? '0 : r_word + 1'b1;
                w_n_phase = w_last_word;
            end
        end else begin
            w_lfsr_nx = (!r_rd && w_last_word) ? r_saved : w_lfsr_step;
            w_n_word  = w_last_word ? '0 : r_word + 1'b1;
            w_n_rd    = r_rd ^ w_last_word;
            if (r_rd && w_last_word) begin
                w_n_phase = 1'b0;
                w_n_slv   = r_slv + 1'b1;
                w_last    = r_slv == SW'(P_NUM - 1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? SETUP : IDLE;
            SETUP:   w_next = ACCESS;
            ACCESS:  w_next = w_complete ? (w_last ? DONE : SETUP) : ACCESS;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        r_state <= !PRESETn ? IDLE : w_next;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_slv          <= '0;
            r_word         <= '0;
            r_phase        <= 1'b0;
            r_rd           <= 1'b0;
            r_tmo          <= '0;
            r_lfsr         <= P_SEED;
            r_saved        <= P_SEED;
            PADDR          <= '1;
            PWRITE         <= 1'b0;
            PWDATA         <= '1;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            r_tmo <= (r_state == ACCESS && !w_rdy) ? r_tmo + 1'b1 : '0;
            if (w_start) begin
                r_slv          <= '0;
                r_word         <= '0;
                r_phase        <= 1'b0;
                r_rd           <= 1'b0;
                r_lfsr         <= P_SEED;
                PADDR          <= P_ADDR_BASE;
                PWRITE         <= 1'b1;
                PWDATA         <= P_SEED[P_DWIDTH-1:0];
                pass           <= 1'b0;
                err_cnt        <= '0;
                first_err_addr <= '0;
            end
            if (w_complete) begin
                r_slv   <= w_n_slv;
                r_word  <= w_n_word;
                r_phase <= w_n_phase;
                r_rd    <= w_n_rd;
                r_lfsr  <= w_lfsr_nx;
                // Snapshot taken as RAAWA begins so its reads can regenerate the written data
                if (!r_phase && r_rd && w_last_word)
                    r_saved <= w_lfsr_nx;
                if (!w_last) begin
                    PADDR  <= w_n_addr;
                    PWRITE <= !w_n_rd;
                    PWDATA <= w_lfsr_nx[P_DWIDTH-1:0];
                end
                if (w_err) begin
                    err_cnt <= err_cnt + 16'(err_cnt != 16'hFFFF);
                    if (err_cnt == '0)
                        first_err_addr <= PADDR;
                end
                if (w_last)
                    pass <= err_cnt == '0 && !w_err;
            end
        end
    end
endmodule

// File: tb/tb_apb_memtest_master.sv
// tb_apb_memtest_master: table-driven and randomized checks of the APB memory-test master
module tb_apb_memtest_master;
    localparam int N = 3;

    typedef struct {
        int          wait1;
        bit          stuck;
        bit          tmo0;
        bit          slverr1;
        bit          rnd;
        bit          mid_start;
        int          exp_err;
        int          exp_cycles;
        logic [31:0] exp_first;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        bit          w;
        logic [31:0] d;
        int          s;
    } xfer_t;

    logic PCLK = 1'b0, PRESETn = 1'b0, start = 1'b0;
    logic [N-1:0] PSEL, PREADY, PSLVERR;
    logic [31:0] PADDR, PWDATA, first_err_addr;
    logic PENABLE, PWRITE, busy, done, pass;
    logic [N*32-1:0] PRDATA;
    logic [15:0] err_cnt;

    int n_chk = 0, n_err = 0;
    int cfg_wait1 = 0;
    bit cfg_stuck = 0, cfg_tmo0 = 0, cfg_slverr1 = 0, cfg_rnd = 0;
    logic [31:0] mem [logic [31:0]];
    int s_cnt = 0, s_wait = 0;
    bit s_err = 0;
    logic [31:0] s_rdata = '0;
    xfer_t exp_q[$];
    int mdl_err = 0, n_xfer = 0, acc = 0, m_sidx;
    logic [31:0] mdl_first = '0, m_rd, s_a, s_d;
    bit proto_bad = 0, unstable = 0, m_tmo, m_bad;
    logic s_w;
    logic [N-1:0] s_sel;
    xfer_t m_e;
    vec_t vt[8];

    apb_memtest_master dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .start(start),
        .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_addr(first_err_addr)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
    endfunction

    function automatic logic [31:0] addr_of(input int s, input int w);
        return 32'(s) * 32'h1000_0000 + 32'(w) * 32'd4;
    endfunction

    // Expected transfer stream: per slave, RAW then RAAWA, one LFSR shared across slaves
    task automatic build_model();
        logic [31:0] l, sv;
        exp_q.delete();
        l = 32'h1234_5678;
        for (int s = 0; s < N; s++) begin
            for (int w = 0; w < 4; w++) begin
                exp_q.push_back('{a: addr_of(s, w), w: 1'b1, d: l, s: s});
                exp_q.push_back('{a: addr_of(s, w), w: 1'b0, d: l, s: s});
                l = lfsr_step(l);
            end
            sv = l;
            for (int w = 0; w < 4; w++) begin
                exp_q.push_back('{a: addr_of(s, w), w: 1'b1, d: l, s: s});
                l = lfsr_step(l);
            end
            l = sv;
            for (int w = 0; w < 4; w++) begin
                exp_q.push_back('{a: addr_of(s, w), w: 1'b0, d: l, s: s});
                l = lfsr_step(l);
            end
        end
    endtask

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        logic [31:0] v;
        v = mem.exists(a) ? mem[a] : 32'h0;
        if (cfg_stuck && a == 32'h2000_0000) v[0] = 1'b0;
        return v;
    endfunction

    function automatic int f_idx(input logic [N-1:0] s);
        for (int i = 0; i < N; i++) if (s[i]) return i;
        return 0;
    endfunction

    // Slave side: wait states and error flags drawn per transfer during SETUP
    always @(posedge PCLK) begin
        if (PSEL != 0 && !PENABLE) begin
            s_cnt   <= 0;
            s_wait  <= cfg_rnd ? int'($urandom_range(3, 0)) : (PSEL[1] ? cfg_wait1 : 0);
            s_err   <= cfg_rnd && ($urandom_range(15, 0) == 0);
            s_rdata <= rd_val(PADDR);
        end else if (PENABLE) begin
            s_cnt <= s_cnt + 1;
        end
    end

    assign PRDATA = {N{s_rdata}};

    always_comb begin
        PREADY = '0;
        for (int i = 0; i < N; i++)
            PREADY[i] = PSEL[i] && PENABLE && !(cfg_tmo0 && i == 0) && s_cnt >= s_wait;
    end

    always_comb begin
        PSLVERR = '0;
        for (int i = 0; i < N; i++)
            PSLVERR[i] = PREADY[i] && (s_err || (cfg_slverr1 && i == 1));
    end

    // Monitor/scoreboard: judges each completed transfer against the expected stream
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            acc = 0;
        end else begin
            if ($countones(PSEL) > 1 || (PENABLE && PSEL == 0) || (busy && PSEL == 0)) proto_bad = 1;
            if (PSEL != 0 && !PENABLE) begin
                acc = 0; s_a = PADDR; s_w = PWRITE; s_d = PWDATA; s_sel = PSEL; unstable = 0;
            end else if (PSEL != 0 && PENABLE) begin
                acc++;
                if (PADDR !== s_a || PWRITE !== s_w || PWDATA !== s_d || PSEL !== s_sel) unstable = 1;
                m_sidx = f_idx(PSEL);
                if (PREADY[m_sidx] || acc == 16) begin
                    m_tmo = !PREADY[m_sidx];
                    n_xfer++;
                    m_rd = PRDATA[m_sidx*32 +: 32];
                    if (exp_q.size() == 0) begin
                        chk("xfer_extra", 32'(n_xfer), 32'd48);
                    end else begin
                        m_e = exp_q.pop_front();
                        chk("xfer_addr", PADDR, m_e.a);
                        chk("xfer_dir", 32'(PWRITE), 32'(m_e.w));
                        chk("xfer_sel", 32'(PSEL), 32'(1 << m_e.s));
                        if (m_e.w) chk("xfer_wdata", PWDATA, m_e.d);
                        m_bad = m_tmo || PSLVERR[m_sidx] || (!m_e.w && m_rd !== m_e.d);
                        if (m_bad) begin
                            if (mdl_err == 0) mdl_first = PADDR;
                            mdl_err++;
                        end
                    end
                    chk("stable", 32'(unstable), 32'd0);
                    if (!cfg_rnd && !m_tmo) chk("access_len", 32'(acc), 32'((m_sidx == 1 ? cfg_wait1 : 0) + 1));
                    if (PWRITE && !m_tmo) mem[PADDR] = PWDATA;
                end
            end
        end
    end

    task automatic setup_cfg(input vec_t v);
        cfg_wait1 = v.wait1; cfg_stuck = v.stuck; cfg_tmo0 = v.tmo0;
        cfg_slverr1 = v.slverr1; cfg_rnd = v.rnd;
        mem.delete();
        build_model();
        mdl_err = 0; mdl_first = '0; n_xfer = 0; proto_bad = 0;
    endtask

    task automatic run_case(input vec_t v);
        int cyc;
        setup_cfg(v);
        @(negedge PCLK); start = 1'b1;
        @(negedge PCLK); start = 1'b0;
        cyc = 1;
        while (!done && cyc < 3000) begin
            start = v.mid_start && cyc == 20;
            @(negedge PCLK);
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        if (v.exp_cycles >= 0) chk("cycles", 32'(cyc), 32'(v.exp_cycles));
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("psel_in_done", 32'(PSEL), 32'd0);
        chk("err_cnt", 32'(err_cnt), 32'(mdl_err));
        chk("pass", 32'(pass), 32'(mdl_err == 0));
        chk("first_err_addr", first_err_addr, mdl_first);
        chk("xfer_count", 32'(n_xfer), 32'd48);
        chk("exp_left", 32'(exp_q.size()), 32'd0);
        chk("protocol", 32'(proto_bad), 32'd0);
        if (v.exp_err >= 0) begin
            chk("tbl_err", 32'(err_cnt), 32'(v.exp_err));
            chk("tbl_pass", 32'(pass), 32'(v.exp_err == 0));
            if (v.exp_err > 0) chk("tbl_first", first_err_addr, v.exp_first);
        end
        @(negedge PCLK);
        chk("done_pulse", 32'(done), 32'd0);
        chk("pass_held", 32'(pass), 32'(mdl_err == 0));
        chk("err_held", 32'(err_cnt), 32'(mdl_err));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_psel"}, 32'(PSEL), 32'd0);
        chk({tag, "_paddr"}, PADDR, 32'hFFFF_FFFF);
        chk({tag, "_penable"}, 32'(PENABLE), 32'd0);
        chk({tag, "_pwrite"}, 32'(PWRITE), 32'd0);
        chk({tag, "_pwdata"}, PWDATA, 32'hFFFF_FFFF);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        chk({tag, "_first"}, first_err_addr, 32'd0);
    endtask

    initial begin
        bit saw_done;
        vt[0] = '{0, 0, 0, 0, 0, 0,  0,  97, 32'h0};
        vt[1] = '{3, 0, 0, 0, 0, 0,  0, 145, 32'h0};
        vt[2] = '{0, 1, 0, 0, 0, 0, -1,  97, 32'h0};
        vt[3] = '{0, 0, 1, 0, 0, 0, 16, 337, 32'h0};
        vt[4] = '{0, 0, 0, 1, 0, 1, 16,  97, 32'h1000_0000};
        vt[5] = '{0, 0, 0, 0, 1, 0, -1,  -1, 32'h0};
        vt[6] = '{0, 1, 0, 0, 1, 0, -1,  -1, 32'h0};
        vt[7] = '{0, 0, 1, 0, 1, 0, -1,  -1, 32'h0};

        repeat (3) @(negedge PCLK);
        chk_reset_vals("reset");
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) run_case(vt[i]);

        setup_cfg(vt[4]);
        @(negedge PCLK); start = 1'b1;
        @(negedge PCLK); start = 1'b0;
        repeat (80) @(negedge PCLK);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        chk("pre_reset_errs", 32'(err_cnt != 0), 32'd1);
        PRESETn = 1'b0;
        @(negedge PCLK);
        chk_reset_vals("midrun");
        PRESETn = 1'b1;
        saw_done = 0;
        repeat (150) begin
            @(negedge PCLK);
            if (done || busy) saw_done = 1;
        end
        chk("no_done_after_reset", 32'(saw_done), 32'd0);
        exp_q.delete();

        run_case(vt[0]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
